// File: rtl/b01_serial_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : b01_serial_ctrl
// Description : Frame sequencer feeding two operands LSB-first into a bit-serial
//               two-line adder and reassembling its serial sum in parallel.
// Revision    : 1.0 - initial release
// =============================================================================
module b01_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             RESET_G,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o,
    output logic             line1_o,
    output logic             line2_o,
    output logic             adder_nreset_o,
    input  logic             outp_i,
    input  logic             overflw_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             nreset_q;

    // The adder clear must follow RESET_G without waiting for a clock edge.
    assign adder_nreset_o = nreset_q & ~RESET_G;

    always_ff @(posedge clock or posedge RESET_G) begin
        if (RESET_G) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
            nreset_q <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            ovf_o    <= 1'b0;
            line1_o  <= 1'b0;
            line2_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        sh_a     <= op_a_i;
                        sh_b     <= op_b_i;
                        result_o <= '0;
                        ovf_o    <= 1'b0;
                        busy_o   <= 1'b1;
                        nreset_q <= 1'b0;
                        line1_o  <= 1'b0;
                        line2_o  <= 1'b0;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    nreset_q <= 1'b1;
                    line1_o  <= sh_a[0];
                    line2_o  <= sh_b[0];
                    sh_a     <= sh_a >> 1;
                    sh_b     <= sh_b >> 1;
                    cnt      <= '0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Adder output lags the line bits by one cycle, so bit 0
                    // becomes visible only once cnt has advanced to 1.
                    if (cnt != '0) begin
                        result_o <= {outp_i, result_o[WIDTH-1:1]};
                        ovf_o    <= ovf_o | overflw_i;
                    end
                    if (cnt == CNT_LAST) begin
                        line1_o <= 1'b0;
                        line2_o <= 1'b0;
                        state   <= S_DRAIN;
                    end else begin
                        line1_o <= sh_a[0];
                        line2_o <= sh_b[0];
                        sh_a    <= sh_a >> 1;
                        sh_b    <= sh_b >> 1;
                        cnt     <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    result_o <= {outp_i, result_o[WIDTH-1:1]};
                    ovf_o    <= ovf_o | overflw_i;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_b01_serial_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_b01_serial_ctrl
// Description : Self-checking bench with a serial adder and a frame-level model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_b01_serial_ctrl;

    localparam int W = 8;

    logic         clock;
    logic         RESET_G;
    logic         start_i;
    logic [W-1:0] op_a_i;
    logic [W-1:0] op_b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         ovf_o;
    logic         line1_o;
    logic         line2_o;
    logic         adder_nreset_o;
    logic         outp_i;
    logic         overflw_i;

    b01_serial_ctrl #(.WIDTH(W)) dut (
        .clock          (clock),
        .RESET_G        (RESET_G),
        .start_i        (start_i),
        .op_a_i         (op_a_i),
        .op_b_i         (op_b_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .result_o       (result_o),
        .ovf_o          (ovf_o),
        .line1_o        (line1_o),
        .line2_o        (line2_o),
        .adder_nreset_o (adder_nreset_o),
        .outp_i         (outp_i),
        .overflw_i      (overflw_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Serial adder: registered sum bit, overflow flag raised with the last sum bit.
    logic add_carry;
    logic add_ovf;
    int   add_bits;
    logic noise;
    logic noise_en;

    always @(posedge clock) begin
        logic [1:0] s;
        if (!adder_nreset_o) begin
            add_carry <= 1'b0;
            outp_i    <= 1'b0;
            add_ovf   <= 1'b0;
            add_bits  <= 0;
        end else begin
            s = 2'(line1_o) + 2'(line2_o) + 2'(add_carry);
            outp_i    <= s[0];
            add_carry <= s[1];
            add_ovf   <= (add_bits == W - 1) && s[1];
            add_bits  <= add_bits + 1;
        end
    end

    assign overflw_i = add_ovf | noise;

    int n_checks;
    int n_errs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: phase 0 = idle, 1 = first cycle after accept, W+3 = done cycle.
    int           phase;
    logic [W-1:0] fa, fb;
    logic [W:0]   sum;
    logic [W-1:0] exp_res;
    logic         exp_ovf;
    logic         exp_nrst;

    task automatic tick();
        logic e1, e2;
        @(posedge clock);
        if (phase == 0) begin
            if (start_i) begin
                fa = op_a_i; fb = op_b_i; phase = 1;
                exp_res = '0; exp_ovf = 1'b0; exp_nrst = 1'b0;
            end
        end else if (phase == W + 3) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == 2) exp_nrst = 1'b1;
        end
        if (phase == W + 3) begin
            sum = {1'b0, fa} + {1'b0, fb};
            exp_res = sum[W-1:0];
            exp_ovf = sum[W];
        end
        @(negedge clock);
        e1 = (phase >= 2 && phase <= W + 1) ? fa[phase-2] : 1'b0;
        e2 = (phase >= 2 && phase <= W + 1) ? fb[phase-2] : 1'b0;
        check("busy", 32'(busy_o), 32'(phase >= 1 && phase <= W + 2));
        check("done", 32'(done_o), 32'(phase == W + 3));
        check("line1", 32'(line1_o), 32'(e1));
        check("line2", 32'(line2_o), 32'(e2));
        check("nreset", 32'(adder_nreset_o), 32'(exp_nrst));
        if (phase == 0 || phase == 1 || phase == W + 3) begin
            check("result", 32'(result_o), 32'(exp_res));
            check("ovf", 32'(ovf_o), 32'(exp_ovf));
        end
        noise = noise_en && (phase == 0 || phase == 1 || phase == W + 3);
    endtask

    // Called right after a negedge: reset pulse that ends before the next posedge.
    task automatic mid_reset();
        #2 RESET_G = 1'b1;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_lines", 32'({line1_o, line2_o}), 32'd0);
        check("rst_nreset", 32'(adder_nreset_o), 32'd0);
        #1 RESET_G = 1'b0;
        phase = 0; exp_res = '0; exp_ovf = 1'b0; exp_nrst = 1'b0;
    endtask

    task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        start_i = 1'b1; op_a_i = a; op_b_i = b;
        tick();
        start_i = 1'b0; op_a_i = ~a; op_b_i = ~b;
        for (int i = 0; i < W + 4; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errs = 0;
        phase = 0; fa = '0; fb = '0; exp_res = '0; exp_ovf = 1'b0; exp_nrst = 1'b0;
        noise = 1'b0; noise_en = 1'b0;
        RESET_G = 1'b1; start_i = 1'b0; op_a_i = '0; op_b_i = '0;
        repeat (2) @(negedge clock);
        check("init_busy", 32'(busy_o), 32'd0);
        check("init_result", 32'(result_o), 32'd0);
        check("init_nreset", 32'(adder_nreset_o), 32'd0);
        #2 RESET_G = 1'b0;
        tick();
        mid_reset();
        tick();

        run_frame(8'h35, 8'h4A);
        check("basic_result", 32'(result_o), 32'h7F);
        run_frame(8'hFF, 8'h01);
        check("carry_ovf", 32'(ovf_o), 32'd1);
        noise_en = 1'b1;
        run_frame(8'h01, 8'h02);
        check("window_ovf", 32'(ovf_o), 32'd0);
        noise_en = 1'b0;

        // Start held high with operands changing every cycle.
        start_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op_a_i = W'($urandom); op_b_i = W'($urandom);
            tick();
        end
        start_i = 1'b0;
        for (int i = 0; i < W + 4; i++) tick();

        // Abort while shifting bit 4.
        start_i = 1'b1; op_a_i = 8'hC3; op_b_i = 8'h5A;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 20 && phase != 6; i++) tick();
        check("abort_phase", 32'(phase), 32'd6);
        mid_reset();
        for (int i = 0; i < W + 6; i++) tick();
        run_frame(8'h10, 8'h20);
        check("post_abort_result", 32'(result_o), 32'h30);

        for (int i = 0; i < 300; i++) begin
            start_i  = ($urandom_range(0, 3) == 0);
            op_a_i   = W'($urandom);
            op_b_i   = W'($urandom);
            noise_en = $urandom_range(0, 1) == 1;
            tick();
        end
        start_i = 1'b0; noise_en = 1'b0;
        for (int i = 0; i < W + 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
